// File: rtl/udp_reg_endpoint_if.sv
// UDP header and 8-bit AXI-Stream bundles shared by the UDP switch port clients.
interface udp_hdr_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] source_ip;
  logic [31:0] dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;

  modport source (output hdr_valid, source_ip, dest_ip, source_port, dest_port, length,
                  input  hdr_ready);
  modport sink   (input  hdr_valid, source_ip, dest_ip, source_port, dest_port, length,
                  output hdr_ready);
endinterface

interface axis8_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/udp_reg_endpoint.sv
// UDP register-access endpoint: parses 7-byte read/write requests into a 32-bit
// register bank and answers each well-formed request with an 8-byte reply.
module udp_reg_endpoint #(
  parameter logic [15:0] UDP_PORT  = 16'd1230,
  parameter int          REG_COUNT = 16,
  parameter logic [31:0] REG_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            local_ip,
  udp_hdr_if.sink                udp_rx_header_if,
  axis8_if.slave                 udp_rx_payload_if,
  udp_hdr_if.source              udp_tx_header_if,
  axis8_if.master                udp_tx_payload_if,
  output logic [32*REG_COUNT-1:0] regs_out,
  output logic                   wr_strobe
);

  localparam int          IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [16:0] REG_LIMIT = 17'(REG_COUNT);
  localparam logic [7:0]  OP_WRITE  = 8'h01;
  localparam logic [7:0]  OP_READ   = 8'h02;
  localparam logic [7:0]  ST_OK     = 8'h00;
  localparam logic [7:0]  ST_BAD_OP = 8'h01;
  localparam logic [7:0]  ST_ADDR   = 8'h02;
  localparam logic [7:0]  ST_SHORT  = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_DROP, S_COMMIT, S_TXH, S_TXP} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [7:0]  op_reg;
  logic [15:0] addr_reg;
  logic [31:0] data_reg;
  logic [31:0] src_ip_reg;
  logic [15:0] src_port_reg;
  logic [63:0] reply_reg;
  logic [2:0]  tx_idx_reg;
  logic [31:0] regs_reg [REG_COUNT];

  logic [7:0]       status_next;
  logic [31:0]      reply_data_next;
  logic [IDX_W-1:0] addr_idx;
  logic             rx_beat;
  logic             unused_rx_fields;

  assign addr_idx = addr_reg[IDX_W-1:0];
  assign rx_beat  = udp_rx_payload_if.tvalid && udp_rx_payload_if.tready;
  assign unused_rx_fields = ^{udp_rx_header_if.dest_ip, udp_rx_header_if.length};

  // cnt_reg holds min(bytes received, 7). Opcode errors take precedence over
  // short frames, which take precedence over address range errors.
  always_comb begin
    status_next     = ST_OK;
    reply_data_next = data_reg;
    if (op_reg != OP_WRITE && op_reg != OP_READ)
      status_next = ST_BAD_OP;
    else if ((op_reg == OP_WRITE && cnt_reg < 3'd7) || (op_reg == OP_READ && cnt_reg < 3'd3))
      status_next = ST_SHORT;
    else if ({1'b0, addr_reg} >= REG_LIMIT)
      status_next = ST_ADDR;
    if (op_reg == OP_READ && status_next == ST_OK)
      reply_data_next = regs_reg[addr_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      src_ip_reg   <= '0;
      src_port_reg <= '0;
      reply_reg    <= '0;
      tx_idx_reg   <= '0;
      wr_strobe    <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs_reg[i] <= REG_RESET;
      udp_rx_header_if.hdr_ready   <= 1'b0;
      udp_rx_payload_if.tready     <= 1'b0;
      udp_tx_header_if.hdr_valid   <= 1'b0;
      udp_tx_header_if.source_ip   <= '0;
      udp_tx_header_if.dest_ip     <= '0;
      udp_tx_header_if.source_port <= '0;
      udp_tx_header_if.dest_port   <= '0;
      udp_tx_header_if.length      <= '0;
      udp_tx_payload_if.tdata      <= '0;
      udp_tx_payload_if.tvalid     <= 1'b0;
      udp_tx_payload_if.tlast      <= 1'b0;
      udp_tx_payload_if.tuser      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (udp_rx_header_if.hdr_valid && udp_rx_header_if.hdr_ready) begin
            udp_rx_header_if.hdr_ready <= 1'b0;
            udp_rx_payload_if.tready   <= 1'b1;
            src_ip_reg   <= udp_rx_header_if.source_ip;
            src_port_reg <= udp_rx_header_if.source_port;
            cnt_reg      <= '0;
            op_reg       <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            state_reg    <= (udp_rx_header_if.dest_port == UDP_PORT) ? S_RX : S_DROP;
          end else begin
            udp_rx_header_if.hdr_ready <= 1'b1;
          end
        end

        S_RX: begin
          if (rx_beat) begin
            case (cnt_reg)
              3'd0:    op_reg          <= udp_rx_payload_if.tdata;
              3'd1:    addr_reg[15:8]  <= udp_rx_payload_if.tdata;
              3'd2:    addr_reg[7:0]   <= udp_rx_payload_if.tdata;
              3'd3:    data_reg[31:24] <= udp_rx_payload_if.tdata;
              3'd4:    data_reg[23:16] <= udp_rx_payload_if.tdata;
              3'd5:    data_reg[15:8]  <= udp_rx_payload_if.tdata;
              3'd6:    data_reg[7:0]   <= udp_rx_payload_if.tdata;
              default: ;
            endcase
            if (cnt_reg != 3'd7) cnt_reg <= cnt_reg + 3'd1;
            if (udp_rx_payload_if.tlast) begin
              udp_rx_payload_if.tready <= 1'b0;
              if (udp_rx_payload_if.tuser) begin
                udp_rx_header_if.hdr_ready <= 1'b1;
                state_reg <= S_IDLE;
              end else begin
                state_reg <= S_COMMIT;
              end
            end
          end
        end

        S_DROP: begin
          if (rx_beat && udp_rx_payload_if.tlast) begin
            udp_rx_payload_if.tready   <= 1'b0;
            udp_rx_header_if.hdr_ready <= 1'b1;
            state_reg <= S_IDLE;
          end
        end

        S_COMMIT: begin
          if (op_reg == OP_WRITE && status_next == ST_OK) begin
            regs_reg[addr_idx] <= data_reg;
            wr_strobe          <= 1'b1;
          end
          reply_reg <= {op_reg | 8'h80, addr_reg, reply_data_next, status_next};
          udp_tx_header_if.hdr_valid   <= 1'b1;
          udp_tx_header_if.dest_ip     <= src_ip_reg;
          udp_tx_header_if.dest_port   <= src_port_reg;
          udp_tx_header_if.source_ip   <= local_ip;
          udp_tx_header_if.source_port <= UDP_PORT;
          udp_tx_header_if.length      <= 16'd16;
          state_reg <= S_TXH;
        end

        S_TXH: begin
          if (udp_tx_header_if.hdr_ready) begin
            udp_tx_header_if.hdr_valid <= 1'b0;
            udp_tx_payload_if.tvalid   <= 1'b1;
            udp_tx_payload_if.tdata    <= reply_reg[63:56];
            udp_tx_payload_if.tlast    <= 1'b0;
            reply_reg  <= reply_reg << 8;
            tx_idx_reg <= '0;
            state_reg  <= S_TXP;
          end
        end

        S_TXP: begin
          // The reply is shifted out MSB-first; tx_idx_reg tracks the byte on the bus.
          if (udp_tx_payload_if.tready) begin
            if (tx_idx_reg == 3'd7) begin
              udp_tx_payload_if.tvalid   <= 1'b0;
              udp_tx_payload_if.tlast    <= 1'b0;
              udp_rx_header_if.hdr_ready <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              udp_tx_payload_if.tdata <= reply_reg[63:56];
              udp_tx_payload_if.tlast <= (tx_idx_reg == 3'd6);
              reply_reg  <= reply_reg << 8;
              tx_idx_reg <= tx_idx_reg + 3'd1;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs_out
    assign regs_out[32*gi +: 32] = regs_reg[gi];
  end

endmodule

// File: tb/tb_udp_reg_endpoint.sv
// Bench for udp_reg_endpoint: directed vector table, randomized requests against a
// byte-level reference model, header/payload backpressure and mid-frame reset.
module tb_udp_reg_endpoint;
  localparam logic [15:0] PORT     = 16'd1230;
  localparam int          NREG     = 16;
  localparam logic [31:0] LOCAL_IP = 32'h0A00_0001;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [31:0]           local_ip = LOCAL_IP;
  logic [32*NREG-1:0]    regs_out;
  logic                  wr_strobe;

  udp_hdr_if rx_hdr ();
  axis8_if   rx_pl ();
  udp_hdr_if tx_hdr ();
  axis8_if   tx_pl ();

  udp_reg_endpoint #(.UDP_PORT(PORT), .REG_COUNT(NREG), .REG_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .local_ip(local_ip),
    .udp_rx_header_if(rx_hdr), .udp_rx_payload_if(rx_pl),
    .udp_tx_header_if(tx_hdr), .udp_tx_payload_if(tx_pl),
    .regs_out(regs_out), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  always @(posedge clk) if (wr_strobe) wr_cnt <= wr_cnt + 1;

  logic [7:0]  frame_bytes [16];
  int          frame_len;
  logic [31:0] model_regs [NREG];
  logic [31:0] cur_ip;
  logic [15:0] cur_port;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    int          len;
    logic [15:0] port;
    bit          bad;
    bit          exp_reply;
    logic [7:0]  exp_st;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_wr;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic check_regs(input string tag);
    int bad = -1;
    for (int i = 0; i < NREG; i++)
      if (regs_out[32*i +: 32] !== model_regs[i] && bad < 0) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s/regs: reg[%0d] got %h expected %h", tag, bad, regs_out[32*bad +: 32], model_regs[bad]);
    end
  endtask

  // Reference: decode the request bytes straight from the byte-layout rules.
  function automatic logic [63:0] model_txn(output bit wr);
    logic [7:0]  b [7];
    logic [7:0]  op, st;
    logic [15:0] addr;
    logic [31:0] data;
    for (int i = 0; i < 7; i++) b[i] = (i < frame_len) ? frame_bytes[i] : 8'h00;
    op   = b[0];
    addr = {b[1], b[2]};
    data = {b[3], b[4], b[5], b[6]};
    wr   = 1'b0;
    if (op != 8'h01 && op != 8'h02)                         st = 8'h01;
    else if ((op == 8'h01 && frame_len < 7) || (op == 8'h02 && frame_len < 3)) st = 8'h03;
    else if (int'(addr) >= NREG)                            st = 8'h02;
    else                                                    st = 8'h00;
    if (st == 8'h00) begin
      if (op == 8'h01) begin
        model_regs[int'(addr)] = data;
        wr = 1'b1;
      end else
        data = model_regs[int'(addr)];
    end
    return {op | 8'h80, addr, data, st};
  endfunction

  function automatic void build_frame(input logic [7:0] op, input logic [15:0] addr,
                                      input logic [31:0] data, input int len);
    frame_bytes[0] = op;
    frame_bytes[1] = addr[15:8];
    frame_bytes[2] = addr[7:0];
    frame_bytes[3] = data[31:24];
    frame_bytes[4] = data[23:16];
    frame_bytes[5] = data[15:8];
    frame_bytes[6] = data[7:0];
    for (int i = 7; i < 16; i++) frame_bytes[i] = 8'($urandom);
    frame_len = len;
  endfunction

  task automatic send_header(input logic [15:0] port, output bit ok);
    #1;
    rx_hdr.hdr_valid   = 1'b1;
    rx_hdr.source_ip   = cur_ip;
    rx_hdr.source_port = cur_port;
    rx_hdr.dest_port   = port;
    rx_hdr.dest_ip     = LOCAL_IP;
    rx_hdr.length      = 16'(8 + frame_len);
    ok = 1'b0;
    for (int g = 0; g < 100 && !ok; g++) begin
      @(negedge clk);
      ok = rx_hdr.hdr_ready;
      @(posedge clk);
    end
    #1 rx_hdr.hdr_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL hdr_timeout: rx hdr_ready got 0 required 1");
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit user, output bit ok);
    #1;
    rx_pl.tvalid = 1'b1;
    rx_pl.tdata  = d;
    rx_pl.tlast  = last;
    rx_pl.tuser  = user & last;
    ok = 1'b0;
    for (int g = 0; g < 100 && !ok; g++) begin
      @(negedge clk);
      ok = rx_pl.tready;
      @(posedge clk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL byte_timeout: rx tready got 0 required 1");
    end
  endtask

  task automatic send_frame(input logic [15:0] port, input bit bad, output bit ok);
    send_header(port, ok);
    for (int i = 0; i < frame_len && ok; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        #1 rx_pl.tvalid = 1'b0;
        @(posedge clk);
      end
      send_byte(frame_bytes[i], i == frame_len - 1, bad, ok);
    end
    #1;
    rx_pl.tvalid = 1'b0;
    rx_pl.tlast  = 1'b0;
    rx_pl.tuser  = 1'b0;
  endtask

  task automatic get_reply(input logic [63:0] exp, input int hold, input string tag);
    logic [31:0] c_dip, c_sip;
    logic [15:0] c_dp, c_sp, c_len;
    logic [63:0] got = '0;
    logic [7:0]  hd = '0;
    logic        hl = 1'b0;
    int unstable = 0, n = 0, tmask = 0, stall_bad = 0, extra = 0;
    bit done = 1'b0, held = 1'b0;
    c_dip = tx_hdr.dest_ip;   c_sip = tx_hdr.source_ip;
    c_dp  = tx_hdr.dest_port; c_sp  = tx_hdr.source_port; c_len = tx_hdr.length;
    check({tag, "/dest_ip"}, c_dip, cur_ip);
    check({tag, "/dest_port"}, c_dp, cur_port);
    check({tag, "/src_port"}, c_sp, PORT);
    check({tag, "/src_ip"}, c_sip, LOCAL_IP);
    check({tag, "/length"}, c_len, 16'd16);
    check({tag, "/no_rx_overlap"}, {rx_hdr.hdr_ready, rx_pl.tready}, 2'b00);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (!tx_hdr.hdr_valid || tx_hdr.dest_ip !== c_dip || tx_hdr.source_ip !== c_sip ||
          tx_hdr.dest_port !== c_dp || tx_hdr.source_port !== c_sp || tx_hdr.length !== c_len)
        unstable++;
    end
    check({tag, "/hdr_stable"}, unstable, 0);
    @(posedge clk);
    #1 tx_hdr.hdr_ready = 1'b1;
    @(posedge clk);
    #1 tx_hdr.hdr_ready = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tx_pl.tready = ($urandom_range(0, 99) < 50);
      @(negedge clk);
      if (held && (!tx_pl.tvalid || tx_pl.tdata !== hd || tx_pl.tlast !== hl)) stall_bad++;
      held = 1'b0;
      if (tx_pl.tvalid && tx_pl.tready) begin
        if (n < 8) got[63-8*n -: 8] = tx_pl.tdata;
        if (tx_pl.tlast) begin
          if (n < 16) tmask |= (1 << n);
          done = 1'b1;
        end
        n++;
      end else if (tx_pl.tvalid) begin
        held = 1'b1;
        hd = tx_pl.tdata;
        hl = tx_pl.tlast;
      end
      @(posedge clk);
      #1;
    end
    tx_pl.tready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tx_pl.tvalid || tx_hdr.hdr_valid) extra++;
    end
    check({tag, "/beats"}, n, 8);
    check({tag, "/tlast_pos"}, tmask, 32'h80);
    check({tag, "/payload"}, got, exp);
    check({tag, "/stall_stable"}, stall_bad, 0);
    check({tag, "/after_reply"}, extra, 0);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] port, input bit bad, input bit exp_reply,
                         input logic [63:0] exp_rep, input int exp_wr, input int hold);
    int w0 = wr_cnt;
    int seen = 0;
    bit ok;
    cur_ip   = $urandom;
    cur_port = 16'($urandom);
    send_frame(port, bad, ok);
    if (!ok) begin
      @(posedge clk);
      return;
    end
    @(negedge clk);
    check({tag, "/latency_commit"}, tx_hdr.hdr_valid, 1'b0);
    @(negedge clk);
    check({tag, "/hdr_valid"}, tx_hdr.hdr_valid, exp_reply);
    if (exp_reply && tx_hdr.hdr_valid) begin
      get_reply(exp_rep, hold, tag);
    end else if (!exp_reply) begin
      repeat (6) begin
        @(negedge clk);
        if (tx_hdr.hdr_valid || tx_pl.tvalid) seen++;
      end
      check({tag, "/no_reply"}, seen, 0);
      check({tag, "/idle_ready"}, rx_hdr.hdr_ready, 1'b1);
    end
    repeat (3) @(negedge clk);
    check({tag, "/wr_strobes"}, wr_cnt - w0, exp_wr);
    check_regs(tag);
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] rep;
    bit          w, ok;
    int          w0, seen;
    logic [7:0]  op;
    logic [15:0] addr, port;
    int          len;
    bit          bad;

    rx_hdr.hdr_valid = 1'b0; rx_hdr.source_ip = '0; rx_hdr.source_port = '0;
    rx_hdr.dest_port = '0;   rx_hdr.dest_ip = '0;   rx_hdr.length = '0;
    rx_pl.tvalid = 1'b0; rx_pl.tdata = '0; rx_pl.tlast = 1'b0; rx_pl.tuser = 1'b0;
    tx_hdr.hdr_ready = 1'b0; tx_pl.tready = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;

    vecs[0]  = '{8'h01, 16'h0003, 32'hDEADBEEF, 7,  PORT,     1'b0, 1'b1, 8'h00, 16'h0003, 32'hDEADBEEF, 1};
    vecs[1]  = '{8'h02, 16'h0003, 32'h00000000, 3,  PORT,     1'b0, 1'b1, 8'h00, 16'h0003, 32'hDEADBEEF, 0};
    vecs[2]  = '{8'h01, 16'h0004, 32'h12345678, 10, 16'd1231, 1'b0, 1'b0, 8'h00, 16'h0000, 32'h00000000, 0};
    vecs[3]  = '{8'h01, 16'h0010, 32'h11223344, 7,  PORT,     1'b0, 1'b1, 8'h02, 16'h0010, 32'h11223344, 0};
    vecs[4]  = '{8'h07, 16'h0002, 32'h55667788, 7,  PORT,     1'b0, 1'b1, 8'h01, 16'h0002, 32'h55667788, 0};
    vecs[5]  = '{8'h01, 16'h0005, 32'hAABBCCDD, 4,  PORT,     1'b0, 1'b1, 8'h03, 16'h0005, 32'hAA000000, 0};
    vecs[6]  = '{8'h01, 16'h0003, 32'h01020304, 7,  PORT,     1'b1, 1'b0, 8'h00, 16'h0000, 32'h00000000, 0};
    vecs[7]  = '{8'h02, 16'h0003, 32'h00000000, 3,  PORT,     1'b0, 1'b1, 8'h00, 16'h0003, 32'hDEADBEEF, 0};
    vecs[8]  = '{8'h02, 16'h1234, 32'h00000000, 2,  PORT,     1'b0, 1'b1, 8'h03, 16'h1200, 32'h00000000, 0};
    vecs[9]  = '{8'h01, 16'h000F, 32'hCAFEF00D, 12, PORT,     1'b0, 1'b1, 8'h00, 16'h000F, 32'hCAFEF00D, 1};
    vecs[10] = '{8'h02, 16'h000F, 32'h99887766, 7,  PORT,     1'b0, 1'b1, 8'h00, 16'h000F, 32'hCAFEF00D, 0};
    vecs[11] = '{8'h02, 16'h0103, 32'h00000000, 3,  PORT,     1'b0, 1'b1, 8'h02, 16'h0103, 32'h00000000, 0};
    vecs[12] = '{8'h01, 16'hFFFF, 32'h0BADF00D, 7,  PORT,     1'b0, 1'b1, 8'h02, 16'hFFFF, 32'h0BADF00D, 0};
    vecs[13] = '{8'h02, 16'h0000, 32'h00000000, 3,  PORT,     1'b0, 1'b1, 8'h00, 16'h0000, 32'h00000000, 0};
    vecs[14] = '{8'h00, 16'h0000, 32'h00000000, 1,  PORT,     1'b0, 1'b1, 8'h01, 16'h0000, 32'h00000000, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/rx_hdr_ready", rx_hdr.hdr_ready, 1'b0);
    check("rst/rx_tready", rx_pl.tready, 1'b0);
    check("rst/tx_hdr_valid", tx_hdr.hdr_valid, 1'b0);
    check("rst/tx_tvalid_tlast_tuser", {tx_pl.tvalid, tx_pl.tlast, tx_pl.tuser}, 3'b000);
    check("rst/wr_strobe", wr_strobe, 1'b0);
    check_regs("rst");
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst/idle_hdr_ready", rx_hdr.hdr_ready, 1'b1);
    @(posedge clk);

    // Directed vector table
    for (int v = 0; v < 15; v++) begin
      build_frame(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].len);
      if (vecs[v].port == PORT && !vecs[v].bad) rep = model_txn(w);
      run_txn($sformatf("vec%0d", v), vecs[v].port, vecs[v].bad, vecs[v].exp_reply,
              {vecs[v].op | 8'h80, vecs[v].exp_addr, vecs[v].exp_data, vecs[v].exp_st},
              vecs[v].exp_wr, (v == 0) ? 20 : int'($urandom_range(0, 3)));
    end

    // Randomized requests against the reference model
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 19))
        0, 1:    op = 8'($urandom_range(3, 255));
        2:       op = 8'h00;
        default: op = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
      endcase
      addr = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, NREG - 1)) : 16'($urandom);
      if ($urandom_range(0, 9) < 8) len = (op == 8'h02) ? int'($urandom_range(3, 7)) : 7;
      else                          len = int'($urandom_range(1, 12));
      port = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, 2000)) : PORT;
      bad  = ($urandom_range(0, 11) == 0);
      build_frame(op, addr, $urandom, len);
      w = 1'b0;
      rep = '0;
      if (port == PORT && !bad) rep = model_txn(w);
      run_txn($sformatf("rnd%0d", r), port, bad, port == PORT && !bad, rep, int'(w),
              int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a write frame abandons it
    cur_ip = $urandom;
    cur_port = 16'($urandom);
    build_frame(8'h01, 16'h0002, 32'h11111111, 7);
    w0 = wr_cnt;
    send_header(PORT, ok);
    for (int i = 0; i < 3 && ok; i++) send_byte(frame_bytes[i], 1'b0, 1'b0, ok);
    #1;
    rx_pl.tvalid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    @(negedge clk);
    check("midrst/rx_ready", {rx_hdr.hdr_ready, rx_pl.tready}, 2'b00);
    check("midrst/tx_hdr_valid", tx_hdr.hdr_valid, 1'b0);
    check_regs("midrst");
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_hdr.hdr_valid || tx_pl.tvalid) seen++;
    end
    check("midrst/no_reply", seen, 0);
    check("midrst/idle_hdr_ready", rx_hdr.hdr_ready, 1'b1);
    check("midrst/no_write", wr_cnt - w0, 0);
    @(posedge clk);
    build_frame(8'h02, 16'h0003, 32'h0, 3);
    rep = model_txn(w);
    run_txn("post_rst_read", PORT, 1'b0, 1'b1, {8'h82, 16'h0003, 32'h00000000, 8'h00}, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
